// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: block FSM state encoding,
// block geometry and the word-write size codes.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } blk_state_t;

  localparam int BLK_BYTES       = 32;
  localparam int BLK_WORDS       = 8;
  localparam int BLK_OFFSET_BITS = $clog2(BLK_BYTES);

  // Size code 0 stands for a full 4-byte word
  localparam logic [1:0] SIZE_4B = 2'd0;
  localparam logic [1:0] SIZE_1B = 2'd1;
  localparam logic [1:0] SIZE_2B = 2'd2;
  localparam logic [1:0] SIZE_3B = 2'd3;

  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SIZE_1B: n = 3'd1;
      SIZE_2B: n = 3'd2;
      SIZE_3B: n = 3'd3;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Overlay the enabled byte lanes of new_word onto old_word
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] w;
    w = old_word;
    for (int l = 0; l < 4; l++) begin
      if (be[l]) w[8*l +: 8] = new_word[8*l +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/dmem_byte_lane_wr.sv
// Byte-lane steering for word writes. Memory is big-endian: byte offset k of
// a word lives in bits [31-8k -: 8], i.e. lane (3-k). be[l] enables
// wdata[8l +: 8]. The low 'size' bytes of data are treated as a big-endian
// value whose most significant byte lands on offset addr_lo; bytes that would
// run past offset 3 are dropped.
module dmem_byte_lane_wr
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata
);

  logic [2:0] nbytes;
  logic [2:0] first;
  logic [2:0] pos;
  logic [1:0] src;

  // Walk the four byte offsets and pick the source byte for each enabled one
  always_comb begin
    be     = '0;
    wdata  = '0;
    pos    = '0;
    src    = '0;
    nbytes = size_to_bytes(size);
    first  = {1'b0, addr_lo};
    for (int off = 0; off < 4; off++) begin
      if (3'(off) >= first) begin
        pos = 3'(off) - first;
        if (pos < nbytes) begin
          src                   = 2'(nbytes - 3'd1 - pos);
          be[3-off]             = 1'b1;
          wdata[8*(3-off) +: 8] = data[8*src +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: 2^ADDR_BITS-byte big-endian store with a
// zero-latency word read port, byte-granular word writes and, when the
// DMEM_BLOCK_EN macro is defined, a fixed-latency 32-byte block read/write
// engine. Without DMEM_BLOCK_EN the block outputs are tied to zero.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int BLK_LATENCY = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  data_address_2DM,
  input  logic         MemRead_2DM,
  input  logic         MemWrite_2DM,
  input  logic [31:0]  data_write_2DM,
  input  logic [1:0]   data_write_size_2DM,
  output logic [31:0]  data_read_fDM,
  input  logic         dBlkRead,
  input  logic         dBlkWrite,
  input  logic [255:0] block_write_2DM,
  output logic [255:0] block_read_fDM,
  output logic         block_read_fDM_valid,
  output logic         block_write_fDM_valid
);

  localparam int WORD_BITS = ADDR_BITS - 2;
  localparam int WORDS     = 1 << WORD_BITS;
  localparam int BLK_BITS  = ADDR_BITS - BLK_OFFSET_BITS;
  localparam int WSEL_BITS = BLK_OFFSET_BITS - 2;

  logic [31:0]          mem [WORDS];
  logic [WORD_BITS-1:0] word_idx;
  logic [3:0]           wr_be;
  logic [31:0]          wr_data;
  logic                 unused_addr;

  // Upper address bits are don't-care: the store wraps modulo 2^ADDR_BITS
  assign unused_addr = ^data_address_2DM[31:ADDR_BITS];
  assign word_idx    = data_address_2DM[ADDR_BITS-1:2];

  dmem_byte_lane_wr u_lane (
    .addr_lo (data_address_2DM[1:0]),
    .size    (data_write_size_2DM),
    .data    (data_write_2DM),
    .be      (wr_be),
    .wdata   (wr_data)
  );

  // Word read is purely combinational and returns pre-edge contents
  assign data_read_fDM = MemRead_2DM ? mem[word_idx] : '0;

`ifdef DMEM_BLOCK_EN
  localparam logic [3:0] CNT_LOAD = 4'(BLK_LATENCY - 1);

  blk_state_t          state, state_nx;
  logic [3:0]          cnt, cnt_nx;
  logic                op_wr, op_wr_nx;
  logic [BLK_BITS-1:0] blk_sel, blk_sel_nx;
  logic                rd_vld, wr_vld;
  logic                capture;
  logic                blk_commit;
  logic [31:0]         snap_word;
  logic [255:0]        blk_snap;
  logic [255:0]        blk_rd_q;

  // Block FSM state register; reset aborts any transaction in flight
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      op_wr   <= 1'b0;
      blk_sel <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      op_wr   <= op_wr_nx;
      blk_sel <= blk_sel_nx;
    end
  end

  // Next-state and completion pulses; write wins when both requests arrive
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    op_wr_nx   = op_wr;
    blk_sel_nx = blk_sel;
    rd_vld     = 1'b0;
    wr_vld     = 1'b0;
    case (state)
      IDLE: begin
        if (dBlkRead || dBlkWrite) begin
          op_wr_nx   = dBlkWrite;
          blk_sel_nx = data_address_2DM[ADDR_BITS-1:BLK_OFFSET_BITS];
          cnt_nx     = CNT_LOAD;
          state_nx   = (BLK_LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_nx = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          cnt_nx   = 4'd0;
          state_nx = DONE;
        end
      end
      DONE: begin
        rd_vld   = !op_wr;
        wr_vld   = op_wr;
        cnt_nx   = 4'd0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The read block is latched on the edge entering DONE so the data is
  // already present while the valid pulse is high
  assign capture    = (state_nx == DONE) && !op_wr_nx;
  assign blk_commit = (state == DONE) && op_wr;

  // Gather the addressed block, forwarding a word write landing on the
  // capture edge so every write issued before DONE is reflected
  always_comb begin
    blk_snap  = '0;
    snap_word = '0;
    for (int i = 0; i < BLK_WORDS; i++) begin
      snap_word = mem[{blk_sel_nx, WSEL_BITS'(i)}];
      if (MemWrite_2DM && (word_idx == {blk_sel_nx, WSEL_BITS'(i)}))
        snap_word = merge_bytes(snap_word, wr_data, wr_be);
      blk_snap[255-32*i -: 32] = snap_word;
    end
  end

  // Block read data register, held until the next read completes
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)        blk_rd_q <= '0;
    else if (capture) blk_rd_q <= blk_snap;
  end

  assign block_read_fDM        = blk_rd_q;
  assign block_read_fDM_valid  = rd_vld;
  assign block_write_fDM_valid = wr_vld;
`else
  logic unused_blk;

  assign unused_blk            = ^{dBlkRead, dBlkWrite, block_write_2DM};
  assign block_read_fDM        = '0;
  assign block_read_fDM_valid  = 1'b0;
  assign block_write_fDM_valid = 1'b0;
`endif

  // Storage update: block commit first, then byte-lane word write so a
  // coincident word write overrides only the bytes it enables
  always_ff @(posedge CLK) begin
`ifdef DMEM_BLOCK_EN
    if (blk_commit) begin
      for (int i = 0; i < BLK_WORDS; i++)
        mem[{blk_sel, WSEL_BITS'(i)}] <= block_write_2DM[255-32*i -: 32];
    end
`endif
    if (MemWrite_2DM) begin
      for (int l = 0; l < 4; l++) begin
        if (wr_be[l]) mem[word_idx][8*l +: 8] <= wr_data[8*l +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (ADDR_BITS=10, BLK_LATENCY=4). Block
// scenarios run only when DMEM_BLOCK_EN is defined; otherwise the bench
// confirms the block interface stays inert.
`timescale 1ns/1ps
module tb_dmem_responder;

  logic         CLK;
  logic         RESET;
  logic [31:0]  data_address_2DM;
  logic         MemRead_2DM;
  logic         MemWrite_2DM;
  logic [31:0]  data_write_2DM;
  logic [1:0]   data_write_size_2DM;
  logic [31:0]  data_read_fDM;
  logic         dBlkRead;
  logic         dBlkWrite;
  logic [255:0] block_write_2DM;
  logic [255:0] block_read_fDM;
  logic         block_read_fDM_valid;
  logic         block_write_fDM_valid;

  int n_cmp;
  int n_bad;

  dmem_responder #(.ADDR_BITS(10), .BLK_LATENCY(4)) dut (
    .CLK                   (CLK),
    .RESET                 (RESET),
    .data_address_2DM      (data_address_2DM),
    .MemRead_2DM           (MemRead_2DM),
    .MemWrite_2DM          (MemWrite_2DM),
    .data_write_2DM        (data_write_2DM),
    .data_write_size_2DM   (data_write_size_2DM),
    .data_read_fDM         (data_read_fDM),
    .dBlkRead              (dBlkRead),
    .dBlkWrite             (dBlkWrite),
    .block_write_2DM       (block_write_2DM),
    .block_read_fDM        (block_read_fDM),
    .block_read_fDM_valid  (block_read_fDM_valid),
    .block_write_fDM_valid (block_write_fDM_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr_word(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    data_address_2DM    = a;
    data_write_2DM      = d;
    data_write_size_2DM = sz;
    MemWrite_2DM        = 1'b1;
    @(posedge CLK); #1;
    MemWrite_2DM        = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    data_address_2DM = a;
    MemRead_2DM      = 1'b1;
    #1;
    chk_eq(tag, data_read_fDM, exp);
    MemRead_2DM      = 1'b0;
    #1;
  endtask

`ifdef DMEM_BLOCK_EN
  // Issue a block request and hold it until a valid pulse; 'at' is the
  // cycle of the pulse counted from the request cycle, -1 if none came
  task automatic run_blk(input logic rd, input logic wr, input logic [31:0] a,
                         output int at, output logic saw_rd, output logic saw_wr);
    at     = -1;
    saw_rd = 1'b0;
    saw_wr = 1'b0;
    @(posedge CLK); #1;
    data_address_2DM = a;
    dBlkRead         = rd;
    dBlkWrite        = wr;
    for (int k = 0; k < 20 && at < 0; k++) begin
      @(negedge CLK);
      if (block_read_fDM_valid || block_write_fDM_valid) begin
        at     = k;
        saw_rd = block_read_fDM_valid;
        saw_wr = block_write_fDM_valid;
      end
      @(posedge CLK); #1;
      if (at >= 0) begin
        dBlkRead  = 1'b0;
        dBlkWrite = 1'b0;
      end
    end
    dBlkRead  = 1'b0;
    dBlkWrite = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] exp_blk;
    logic [255:0] bw;
    int           at;
    logic         srd, swr, seen;

    n_cmp = 0;
    n_bad = 0;
    exp_blk = '0;
    bw      = '0;
    at      = 0;
    srd     = 1'b0;
    swr     = 1'b0;
    seen    = 1'b0;
    RESET               = 1'b1;
    data_address_2DM    = '0;
    MemRead_2DM         = 1'b0;
    MemWrite_2DM        = 1'b0;
    data_write_2DM      = '0;
    data_write_size_2DM = '0;
    dBlkRead            = 1'b0;
    dBlkWrite           = 1'b0;
    block_write_2DM     = '0;

    repeat (3) @(posedge CLK);
    #1;
    chk_eq("rst_rd_vld", block_read_fDM_valid, 0);
    chk_eq("rst_wr_vld", block_write_fDM_valid, 0);
    chk_eq("rst_blk_data", block_read_fDM, 0);
    chk_eq("rst_read_gated", data_read_fDM, 0);
    RESET = 1'b0;
    @(posedge CLK); #1;

    // Word writes: full word, then partial writes with byte dropping
    wr_word(32'h10, 32'hAABBCCDD, 2'd0);
    rd_chk("w4_at10", 32'h10, 32'hAABBCCDD);
    wr_word(32'h11, 32'h000000EE, 2'd1);
    rd_chk("w1_off1", 32'h10, 32'hAAEECCDD);
    wr_word(32'h12, 32'h00112233, 2'd3);
    rd_chk("w3_off2_drop", 32'h10, 32'hAAEE1122);
    wr_word(32'h13, 32'h00005566, 2'd2);
    rd_chk("w2_off3_drop", 32'h13, 32'hAAEE1155);
    wr_word(32'h20, 32'h01020304, 2'd0);
    wr_word(32'h21, 32'hFFFFA1B2, 2'd2);
    rd_chk("w2_off1", 32'h20, 32'h01A1B204);
    wr_word(32'h24, 32'h11223344, 2'd0);
    wr_word(32'h24, 32'hFFFFFF99, 2'd1);
    rd_chk("w1_off0_lowbits_ignored", 32'h27, 32'h99223344);

    data_address_2DM = 32'h10;
    MemRead_2DM      = 1'b0;
    #1;
    chk_eq("read_gated_low", data_read_fDM, 0);

    // Address wrap: 0x400 aliases 0x000, upper bits ignored
    wr_word(32'h400, 32'hCAFEF00D, 2'd0);
    rd_chk("alias_400_000", 32'h000, 32'hCAFEF00D);
    rd_chk("alias_upper_bits", 32'hFFFFFC02, 32'hCAFEF00D);

    // Read and write in the same cycle: read sees old data, write commits
    @(posedge CLK); #1;
    data_address_2DM    = 32'h10;
    data_write_2DM      = 32'h99887766;
    data_write_size_2DM = 2'd0;
    MemRead_2DM         = 1'b1;
    MemWrite_2DM        = 1'b1;
    #1;
    chk_eq("rdwr_pre_data", data_read_fDM, 32'hAAEE1155);
    @(posedge CLK); #1;
    MemWrite_2DM = 1'b0;
    chk_eq("rdwr_post_data", data_read_fDM, 32'h99887766);
    MemRead_2DM = 1'b0;

`ifdef DMEM_BLOCK_EN
    // Preload block at 0x20, then block read with a word write before DONE
    for (int i = 0; i < 8; i++) wr_word(32'h20 + 32'(4*i), 32'h20000000 + 32'(i), 2'd0);
    for (int i = 0; i < 8; i++) exp_blk[255-32*i -: 32] = 32'h20000000 + 32'(i);
    exp_blk[31:0] = 32'h77777777;
    @(posedge CLK); #1;
    data_address_2DM = 32'h20;
    dBlkRead         = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 3) begin
        data_address_2DM    = 32'h3C;
        data_write_2DM      = 32'h77777777;
        data_write_size_2DM = 2'd0;
        MemWrite_2DM        = 1'b1;
      end else begin
        MemWrite_2DM = 1'b0;
      end
      @(negedge CLK);
      chk_eq($sformatf("blkrd_vld_c%0d", k), block_read_fDM_valid, (k == 4));
      chk_eq($sformatf("blkrd_no_wr_vld_c%0d", k), block_write_fDM_valid, 0);
      if (k == 4) chk_eq("blkrd_data_20", block_read_fDM, exp_blk);
      @(posedge CLK); #1;
      if (k == 4) dBlkRead = 1'b0;
    end
    MemWrite_2DM = 1'b0;
    chk_eq("blkrd_data_held", block_read_fDM, exp_blk);
    rd_chk("blkrd_word0_big_end", 32'h20, 32'h20000000);

    // Simultaneous read+write request: write wins
    for (int i = 0; i < 8; i++) bw[255-32*i -: 32] = 32'hB0000000 + 32'(i);
    block_write_2DM = bw;
    run_blk(1'b1, 1'b1, 32'h40, at, srd, swr);
    chk_eq("both_req_latency", 32'(at), 32'd4);
    chk_eq("both_req_wr_pulse", swr, 1);
    chk_eq("both_req_no_rd_pulse", srd, 0);
    @(negedge CLK);
    chk_eq("both_req_single_pulse", {block_read_fDM_valid, block_write_fDM_valid}, 0);
    block_write_2DM = '0;
    run_blk(1'b1, 1'b0, 32'h40, at, srd, swr);
    chk_eq("readback_latency", 32'(at), 32'd4);
    chk_eq("readback_rd_pulse", srd, 1);
    chk_eq("readback_data_40", block_read_fDM, bw);
    rd_chk("blkwr_word5", 32'h54, 32'hB0000005);

    // Reset during BUSY of a block write aborts it
    for (int i = 0; i < 8; i++) wr_word(32'h80 + 32'(4*i), 32'h80000000 + 32'(i), 2'd0);
    @(posedge CLK); #1;
    block_write_2DM  = '1;
    data_address_2DM = 32'h80;
    dBlkWrite        = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET     = 1'b1;
    dBlkWrite = 1'b0;
    #2;
    chk_eq("rst_mid_blk_data_cleared", block_read_fDM, 0);
    RESET = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      seen = seen | block_write_fDM_valid | block_read_fDM_valid;
      @(posedge CLK); #1;
    end
    chk_eq("rst_abort_no_pulse", seen, 0);
    for (int i = 0; i < 8; i++)
      rd_chk($sformatf("rst_abort_mem_w%0d", i), 32'h80 + 32'(4*i), 32'h80000000 + 32'(i));
    for (int i = 0; i < 8; i++) exp_blk[255-32*i -: 32] = 32'h80000000 + 32'(i);
    block_write_2DM = '0;
    run_blk(1'b1, 1'b0, 32'h80, at, srd, swr);
    chk_eq("post_rst_idle_latency", 32'(at), 32'd4);
    chk_eq("post_rst_blk_data", block_read_fDM, exp_blk);
`else
    // Block interface must stay inert; word access keeps working
    @(posedge CLK); #1;
    data_address_2DM = 32'h20;
    block_write_2DM  = '1;
    dBlkRead         = 1'b1;
    for (int k = 0; k < 8; k++) begin
      dBlkWrite = (k >= 4);
      @(negedge CLK);
      chk_eq($sformatf("noblk_vld_c%0d", k), {block_read_fDM_valid, block_write_fDM_valid}, 0);
      chk_eq($sformatf("noblk_data_c%0d", k), block_read_fDM, 0);
      @(posedge CLK); #1;
    end
    rd_chk("noblk_word_read", 32'h20, 32'h01A1B204);
    dBlkRead  = 1'b0;
    dBlkWrite = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10: byte-address bits decoded, giving a 2^ADDR_BITS-byte store.
REQ-002 SHALL have parameter BLK_LATENCY, default 4: cycles from block-request acceptance to the valid pulse; legal range 1..15.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port data_address_2DM  input  32  byte address for word and block access.
REQ-006 SHALL have port MemRead_2DM  input  1  word-read request.
REQ-007 SHALL have port MemWrite_2DM  input  1  word-write request.
REQ-008 SHALL have port data_write_2DM  input  32  write data; the low-order bytes are used.
REQ-009 SHALL have port data_write_size_2DM  input  2  byte count: 1, 2 or 3 bytes; 0 means 4 bytes.
REQ-010 SHALL have port data_read_fDM  output  32  word-read data.
REQ-011 SHALL have port dBlkRead  input  1  block-read request, held until valid.
REQ-012 SHALL have port dBlkWrite  input  1  block-write request, held until valid.
REQ-013 SHALL have port block_write_2DM  input  256  block write data.
REQ-014 SHALL have port block_read_fDM  output  256  block read data.
REQ-015 SHALL have port block_read_fDM_valid  output  1  one-cycle completion pulse for a block read.
REQ-016 SHALL have port block_write_fDM_valid  output  1  one-cycle completion pulse for a block write.

Function
REQ-017 Byte order SHALL be big-endian: byte at word offset 0 maps to bits [31:24].
REQ-018 Addresses SHALL wrap modulo 2^ADDR_BITS; upper address bits are ignored.
REQ-019 Word reads SHALL be combinational, with zero latency: data_read_fDM = word at address[ADDR_BITS-1:2], with address[1:0] ignored; output is 0 when MemRead_2DM=0.
REQ-020 Word writes SHALL commit at the clock edge. size bytes are written from the low bytes of data_write_2DM, starting at address[1:0] and ascending.
REQ-021 Bytes of a word write that fall past the word boundary SHALL be dropped.
REQ-022 If MemRead_2DM and MemWrite_2DM are both high, the write SHALL commit and the read SHALL return the pre-write data.
REQ-023 The FSM SHALL have the states IDLE, BUSY and DONE.
REQ-024 In IDLE, when dBlkRead or dBlkWrite is high, the FSM SHALL latch address[ADDR_BITS-1:5] and the operation, load the counter with BLK_LATENCY-1, and go to BUSY (or to DONE if BLK_LATENCY=1).
REQ-025 When dBlkRead and dBlkWrite are high together, write SHALL win.
REQ-026 In BUSY, the counter SHALL decrement each cycle, going to DONE when it reaches 0.
REQ-027 In DONE, the matching valid output SHALL be high for exactly one cycle. A read captures the 8 words into block_read_fDM; a write commits block_write_2DM, sampled that cycle. The FSM then returns to IDLE.
REQ-028 Block word i SHALL occupy bits [255-32i -: 32].
REQ-029 block_read_fDM SHALL hold its value until the next read DONE.
REQ-030 Requests SHALL be ignored outside IDLE; a request still high in the cycle after DONE starts a new transaction.
REQ-031 Word accesses SHALL be served in every FSM state; a word write made before a block read's DONE is visible in the captured block.

Reset
REQ-032 On RESET, the FSM SHALL go to IDLE, the counter to 0, both valid outputs to 0, and block_read_fDM to 0; any in-flight block write is aborted and not committed.
REQ-033 Storage contents SHALL NOT be altered by RESET.

Configuration
REQ-034 When DMEM_BLOCK_EN is defined, the FSM and block ports SHALL behave as specified above.
REQ-035 When DMEM_BLOCK_EN is undefined, the FSM SHALL be absent; both valid outputs and block_read_fDM are constant 0; dBlkRead, dBlkWrite and block_write_2DM are ignored; word access is unchanged.

Structure
REQ-036 A shared package SHALL hold the state encoding (IDLE=0, BUSY=1, DONE=2), the block size of 32 bytes / 8 words, and the size-code constants.
REQ-037 One sub-module, dmem_byte_lane_wr, SHALL generate the 4-bit byte-enable and aligned write data from address[1:0] and size.

Verification
REQ-038 Word write 0xAABBCCDD, size 0, at 0x10; then read 0x10 -> 0xAABBCCDD in the same cycle as MemRead_2DM.
REQ-039 Write 0x000000EE, size 1, at 0x11 over 0xAABBCCDD -> read 0xAAEECCDD; size 3 at 0x12 -> only bytes 2..3 change.
REQ-040 BLK_LATENCY=4: dBlkRead at 0x20 in cycle 0 -> block_read_fDM_valid high in cycle 4 only; word at 0x20 appears in bits [255:224].
REQ-041 dBlkRead and dBlkWrite together at 0x40 -> write valid pulse only; a subsequent block read returns block_write_2DM.
REQ-042 RESET asserted in BUSY of a block write -> no valid pulse and memory unchanged; after release, state is IDLE.
REQ-043 Address 0x400 with ADDR_BITS=10 -> aliases to 0x000; with DMEM_BLOCK_EN undefined, dBlkRead -> valid stays 0.
